// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit: instruction-sequencing FSM, condition-code evaluation,
// NZCV flag storage and condition-gated architectural write enables.
module arm_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    typedef struct packed {
        logic       nextpc;
        logic       branch;
        logic       regw;
        logic       memw;
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
    } ctrl_t;

    state_t     st;
    ctrl_t      ctrl;
    logic [3:0] nzcv;
    logic       condex;
    logic       pcs;
    logic [3:0] cmd;

    assign cmd = Funct[4:1];

    function automatic state_t next_of(input state_t s, input logic [1:0] op, input logic [5:0] funct);
        case (s)
            FETCH:  next_of = DECODE;
            DECODE: case (op)
                        2'b00:   next_of = funct[5] ? EXECI : EXECR;
                        2'b01:   next_of = MEMADR;
                        2'b10:   next_of = BRANCH;
                        default: next_of = FETCH;
                    endcase
            MEMADR: next_of = funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_of = MEMWB;
            EXECR:  next_of = ALUWB;
            EXECI:  next_of = ALUWB;
            default: next_of = FETCH;
        endcase
    endfunction

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.alusrca = 1'b1;
                          c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            DECODE: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            MEMADR: c.alusrcb = 2'b01;
            MEMRD:  c.adrsrc = 1'b1;
            MEMWB:  begin c.resultsrc = 2'b01; c.regw = 1'b1; end
            MEMWR:  begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECR:  c.aluop = 1'b1;
            EXECI:  begin c.alusrcb = 2'b01; c.aluop = 1'b1; end
            ALUWB:  c.regw = 1'b1;
            BRANCH: begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Control fields are registered alongside the state so they leave flops glitch-free.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            st   <= FETCH;
            ctrl <= decode_state(FETCH);
            nzcv <= 4'b0000;
        end else begin
            st   <= next_of(st, Op, Funct);
            ctrl <= decode_state(next_of(st, Op, Funct));
            if (st == ALUWB && Op == 2'b00 && Funct[0] && condex) begin
                nzcv[3:2] <= ALUFlags[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010)
                    nzcv[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'b0000: condex = nzcv[2];
            4'b0001: condex = !nzcv[2];
            4'b0010: condex = nzcv[1];
            4'b0011: condex = !nzcv[1];
            4'b0100: condex = nzcv[3];
            4'b0101: condex = !nzcv[3];
            4'b0110: condex = nzcv[0];
            4'b0111: condex = !nzcv[0];
            4'b1000: condex = nzcv[1] & !nzcv[2];
            4'b1001: condex = !nzcv[1] | nzcv[2];
            4'b1010: condex = (nzcv[3] == nzcv[0]);
            4'b1011: condex = (nzcv[3] != nzcv[0]);
            4'b1100: condex = !nzcv[2] & (nzcv[3] == nzcv[0]);
            4'b1101: condex = nzcv[2] | (nzcv[3] != nzcv[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (rst_n && ctrl.aluop) begin
            case (cmd)
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    // rst_n gates the outputs combinationally so an aborted instruction cannot write
    // during the cycle in which reset is first seen.
    assign pcs       = ctrl.branch | (ctrl.regw & (Rd == 4'd15));
    assign PCWrite   = rst_n & (ctrl.nextpc | (pcs & condex));
    assign RegWrite  = rst_n & ctrl.regw & condex & (Rd != 4'd15);
    assign MemWrite  = rst_n & ctrl.memw & condex;
    assign IRWrite   = rst_n & ctrl.irwrite;
    assign AdrSrc    = rst_n ? ctrl.adrsrc    : 1'b0;
    assign ALUSrcA   = rst_n ? ctrl.alusrca   : 1'b1;
    assign ALUSrcB   = rst_n ? ctrl.alusrcb   : 2'b10;
    assign ResultSrc = rst_n ? ctrl.resultsrc : 2'b10;
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign state     = st;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: per-cycle expected outputs are queued when stimulus
// is driven and compared on the following falling edge.
module tb_arm_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] state;

    arm_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, memw, regw, irw, adr, srca;
        logic [1:0] srcb, res, aluc, imm, regsrc;
    } out_t;

    typedef struct {
        logic       rst;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] fl;
        logic [3:0] st;
        logic [3:0] wr;   // {PCWrite, MemWrite, RegWrite, IRWrite}
        logic [1:0] aluc;
    } vec_t;

    localparam logic [3:0] W_NONE = 4'b0000, W_FETCH = 4'b1001, W_PC = 4'b1000,
                           W_MEM  = 4'b0100, W_REG   = 4'b0010;

    vec_t tbl[$];
    out_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc_idx = 0;

    logic [3:0] cur_cond, cur_rd, cur_fl;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;

    function automatic vec_t mk(input logic rst, input logic [3:0] st, input logic [3:0] wr,
                                input logic [1:0] aluc);
        vec_t v;
        v.rst = rst; v.cond = cur_cond; v.op = cur_op; v.funct = cur_funct; v.rd = cur_rd;
        v.fl = cur_fl; v.st = st; v.wr = wr; v.aluc = aluc;
        return v;
    endfunction

    // Expected mux selects per state; a reset cycle shows the FETCH selects.
    function automatic out_t expect_of(input vec_t v);
        out_t e;
        e = '0;
        e.st = v.st;
        {e.pcw, e.memw, e.regw, e.irw} = v.rst ? v.wr : 4'b0000;
        e.aluc   = v.aluc;
        e.imm    = v.op;
        e.regsrc = {v.op == 2'b01, v.op == 2'b10};
        case (v.rst ? v.st : 4'd0)
            4'd0, 4'd1: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
            4'd2:       e.srcb = 2'b01;
            4'd3:       e.adr = 1'b1;
            4'd4:       e.res = 2'b01;
            4'd5:       e.adr = 1'b1;
            4'd7:       e.srcb = 2'b01;
            4'd9:       begin e.srcb = 2'b01; e.res = 2'b10; end
            default:    e.adr = 1'b0;
        endcase
        return e;
    endfunction

    task automatic ins(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] fl);
        cur_cond = cond; cur_op = op; cur_funct = funct; cur_rd = rd; cur_fl = fl;
    endtask

    task automatic cyc(input logic [3:0] st, input logic [3:0] wr, input logic [1:0] aluc = 2'b00);
        tbl.push_back(mk(1'b1, st, wr, aluc));
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst_n = v.rst; Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.fl;
        sb.push_back(expect_of(v));
    endtask

    task automatic step(input logic rst, input logic [3:0] st, input logic [3:0] wr,
                        input logic [1:0] aluc = 2'b00);
        apply(mk(rst, st, wr, aluc));
    endtask

    task automatic check(input string name, input out_t got, input out_t req);
        total++;
        if (got === req) passed++;
        else $display("FAIL %s: got %h required %h", name, got, req);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            out_t req, got;
            req = sb.pop_front();
            got = {state, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
            check($sformatf("cycle%0d", cyc_idx), got, req);
            cyc_idx++;
        end
    end

    initial begin
        rst_n = 1'b0; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0;

        ins(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
        tbl.push_back(mk(1'b0, 4'd0, W_NONE, 2'b00));
        // BEQ with Z=0 straight out of reset: not taken.
        ins(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_NONE);
        // ADDS R1, imm: sets NZCV=0110.
        ins(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(7, W_NONE, 2'b00); cyc(8, W_REG);
        // BEQ with Z=1: taken in BRANCH.
        ins(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_PC);
        // SUBSNE while Z=1: no write, flags kept.
        ins(4'b0001, 2'b00, 6'b000101, 4'd3, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(6, W_NONE, 2'b01); cyc(8, W_NONE);
        ins(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_PC);
        // LDR R2.
        ins(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(2, W_NONE); cyc(3, W_NONE); cyc(4, W_REG);
        // STR R2.
        ins(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(2, W_NONE); cyc(5, W_MEM);
        // ORR PC: write redirected to PCWrite.
        ins(4'b1110, 2'b00, 6'b011000, 4'd15, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(6, W_NONE, 2'b11); cyc(8, W_PC);
        // Cond=1111 ORR PC and STR: nothing written.
        ins(4'b1111, 2'b00, 6'b011000, 4'd15, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(6, W_NONE, 2'b11); cyc(8, W_NONE);
        ins(4'b1111, 2'b01, 6'b011000, 4'd2, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(2, W_NONE); cyc(5, W_NONE);
        // Undefined opcode: two-cycle NOP.
        ins(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE);
        // Unlisted cmd 0001 decodes to ADD control.
        ins(4'b1110, 2'b00, 6'b100010, 4'd5, 4'b0000);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(7, W_NONE, 2'b00); cyc(8, W_REG);
        // ANDS with ALUFlags=1011: N,Z take 1,0; C,V stay 1,0.
        ins(4'b1110, 2'b00, 6'b100001, 4'd4, 4'b1011);
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(7, W_NONE, 2'b10); cyc(8, W_REG);
        ins(4'b1010, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BGE: N!=V, not taken
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_NONE);
        ins(4'b1011, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BLT: taken
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_PC);
        ins(4'b0010, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BCS: C kept at 1
        cyc(0, W_FETCH); cyc(1, W_NONE); cyc(9, W_PC);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset held two cycles from the middle of EXECR aborts the SUB and clears NZCV.
        ins(4'b1110, 2'b00, 6'b000100, 4'd6, 4'b0000);
        step(1'b1, 4'd0, W_FETCH);
        step(1'b1, 4'd1, W_NONE);
        step(1'b0, 4'd6, W_NONE);
        step(1'b0, 4'd0, W_NONE);
        ins(4'b0100, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BMI: N cleared, not taken
        step(1'b1, 4'd0, W_FETCH);
        step(1'b1, 4'd1, W_NONE);
        step(1'b1, 4'd9, W_NONE);
        ins(4'b0010, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BCS: C cleared, not taken
        step(1'b1, 4'd0, W_FETCH);
        step(1'b1, 4'd1, W_NONE);
        step(1'b1, 4'd9, W_NONE);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
